// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - FSM state encoding (2 bits)
//   - FaultCause codes
//   - default halt opcode and instruction-word field positions
//   - next-PC select codes used between the FSM and the PC register
package instr_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HALT  = 2'b11
    } ifc_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'b00,
        PC_INC      = 2'b01,
        PC_REDIRECT = 2'b10
    } pc_sel_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/ifc_pc_reg.sv
// PC register for the fetch sequencer, with next-PC mux and address checks.
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous active-high reset, loads RESET_PC
//   pc_sel           in   hold / +4 / redirect select
//   redirect_addr    in   branch/jump target
//   pc               out  current PC
//   out_of_range     out  PC is past the last whole word of instruction memory
//   redirect_misalign out redirect target is not word aligned
module ifc_pc_reg
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  pc_sel_e     pc_sel,
    input  logic [31:0] redirect_addr,
    output logic [31:0] pc,
    output logic        out_of_range,
    output logic        redirect_misalign
);

    localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

    logic [31:0] pc_nxt;

    always_comb begin
        pc_nxt = pc;
        case (pc_sel)
            PC_INC:      pc_nxt = pc + 32'd4;
            PC_REDIRECT: pc_nxt = redirect_addr;
            default:     pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // Checked against the un-incremented PC so a redirect to a bad target
    // only faults when that target is actually fetched.
    assign out_of_range      = (pc > LAST_WORD_ADDR);
    assign redirect_misalign = (redirect_addr[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for the multi-cycle CPU. Owns the PC, drives IAddr into the
// combinational-read instruction memory, latches the word into IR and hands it
// to the control unit over an IRValid/IRReady handshake. Applies redirects,
// stops on the halt opcode or on a fault, and counts consumed instructions.
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   Start                 leave IDLE and begin fetching
//   IAddr / IDataOut      instruction memory address (= PC) and returned word
//   IR, IRValid, IRReady  latched instruction and its handshake
//   PC                    address of the next fetch
//   PCRedirect, RedirectAddr  branch/jump target, taken on a handshake
//   Halt, FaultCause      stop flag and reason (00 none, 01 misaligned, 10 range)
//   FetchCnt              wrapping count of consumed instructions
//
// state | meaning
// IDLE  | waiting for Start after reset
// FETCH | range-check PC, latch IDataOut into IR, advance PC
// WAIT  | IR valid, waiting for the control unit to accept it
// HALT  | stopped by halt opcode or fault, held until reset
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 128,
    parameter logic [5:0]  HALT_OP   = HALT_OP_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    output logic [31:0]      IAddr,
    input  logic [31:0]      IDataOut,
    output logic [31:0]      IR,
    output logic             IRValid,
    input  logic             IRReady,
    output logic [31:0]      PC,
    input  logic             PCRedirect,
    input  logic [31:0]      RedirectAddr,
    output logic             Halt,
    output logic [1:0]       FaultCause,
    output logic [CNT_W-1:0] FetchCnt
);

    ifc_state_e  state, state_nxt;
    pc_sel_e     pc_sel;
    logic        out_of_range;
    logic        redirect_misalign;
    logic        handshake;
    logic        ir_load;
    logic        halt_set;
    logic [1:0]  fault_nxt;

    ifc_pc_reg #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_reg (
        .clk               (CLK),
        .reset             (Reset),
        .pc_sel            (pc_sel),
        .redirect_addr     (RedirectAddr),
        .pc                (PC),
        .out_of_range      (out_of_range),
        .redirect_misalign (redirect_misalign)
    );

    assign IAddr     = PC;
    assign handshake = (state == ST_WAIT) && IRValid && IRReady;

    always_comb begin
        state_nxt = state;
        pc_sel    = PC_HOLD;
        ir_load   = 1'b0;
        halt_set  = 1'b0;
        fault_nxt = FAULT_NONE;
        case (state)
            ST_IDLE: begin
                if (Start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (out_of_range) begin
                    halt_set  = 1'b1;
                    fault_nxt = FAULT_RANGE;
                    state_nxt = ST_HALT;
                end else begin
                    ir_load   = 1'b1;
                    pc_sel    = PC_INC;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (handshake) begin
                    if (opcode_of(IR) == HALT_OP) begin
                        halt_set  = 1'b1;
                        state_nxt = ST_HALT;
                    end else if (PCRedirect && redirect_misalign) begin
                        halt_set  = 1'b1;
                        fault_nxt = FAULT_MISALIGN;
                        state_nxt = ST_HALT;
                    end else if (PCRedirect) begin
                        pc_sel    = PC_REDIRECT;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ST_IDLE;
            IR         <= '0;
            IRValid    <= 1'b0;
            Halt       <= 1'b0;
            FaultCause <= FAULT_NONE;
            FetchCnt   <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                IR      <= IDataOut;
                IRValid <= 1'b1;
            end else if (handshake) begin
                IRValid <= 1'b0;
            end
            if (handshake) FetchCnt <= FetchCnt + 1'b1;
            if (halt_set) begin
                Halt       <= 1'b1;
                FaultCause <= fault_nxt;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset, Start, IRReady, PCRedirect;
    logic [31:0] RedirectAddr, IDataOut, IAddr, IR, PC;
    logic        IRValid, Halt;
    logic [1:0]  FaultCause;
    logic [15:0] FetchCnt;

    logic [7:0] mem [0:127];
    int n_pass = 0;
    int n_total = 0;

    instr_fetch_ctrl dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .IAddr        (IAddr),
        .IDataOut     (IDataOut),
        .IR           (IR),
        .IRValid      (IRValid),
        .IRReady      (IRReady),
        .PC           (PC),
        .PCRedirect   (PCRedirect),
        .RedirectAddr (RedirectAddr),
        .Halt         (Halt),
        .FaultCause   (FaultCause),
        .FetchCnt     (FetchCnt)
    );

    always #5 CLK = ~CLK;

    // Big-endian combinational instruction memory
    always_comb begin
        IDataOut = 32'h0;
        if (IAddr < 32'd125) begin
            IDataOut = {mem[IAddr[6:0]], mem[IAddr[6:0] + 7'd1],
                        mem[IAddr[6:0] + 7'd2], mem[IAddr[6:0] + 7'd3]};
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; Start = 1'b0; IRReady = 1'b0; PCRedirect = 1'b0;
        RedirectAddr = 32'h0;
        tick(2);
        Reset = 1'b0;
    endtask

    // From reset: Start, then one FETCH cycle -> WAIT holding word at 0
    task automatic start_to_first_wait();
        do_reset();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (PC !== 32'h0) $display("FAIL reset_pc: got %h want %h", PC, 32'h0); else n_pass++;
        n_total++; if (IAddr !== 32'h0) $display("FAIL reset_iaddr: got %h want %h", IAddr, 32'h0); else n_pass++;
        n_total++; if (IR !== 32'h0) $display("FAIL reset_ir: got %h want %h", IR, 32'h0); else n_pass++;
        n_total++; if (IRValid !== 1'b0) $display("FAIL reset_irvalid: got %b want 0", IRValid); else n_pass++;
        n_total++; if (Halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", Halt); else n_pass++;
        n_total++; if (FaultCause !== 2'b00) $display("FAIL reset_fault: got %b want 00", FaultCause); else n_pass++;
        n_total++; if (FetchCnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", FetchCnt); else n_pass++;
        tick(3);
        n_total++; if (IRValid !== 1'b0 || PC !== 32'h0) $display("FAIL idle_hold: irvalid %b pc %h want 0 and 0", IRValid, PC); else n_pass++;
    endtask

    task automatic test_sequential_fetch();
        start_to_first_wait();
        n_total++; if (IR !== 32'h0022_1800) $display("FAIL seq_ir0: got %h want %h", IR, 32'h0022_1800); else n_pass++;
        n_total++; if (IRValid !== 1'b1) $display("FAIL seq_valid0: got %b want 1", IRValid); else n_pass++;
        n_total++; if (PC !== 32'h4) $display("FAIL seq_pc0: got %h want %h", PC, 32'h4); else n_pass++;
        IRReady = 1'b1;
        tick(1);
        n_total++; if (IRValid !== 1'b0 || FetchCnt !== 16'd1) $display("FAIL seq_hs0: irvalid %b cnt %0d want 0 and 1", IRValid, FetchCnt); else n_pass++;
        tick(1);
        n_total++; if (IR !== 32'h0822_0224) $display("FAIL seq_ir1: got %h want %h", IR, 32'h0822_0224); else n_pass++;
        n_total++; if (PC !== 32'h8) $display("FAIL seq_pc1: got %h want %h", PC, 32'h8); else n_pass++;
        tick(1);
        n_total++; if (FetchCnt !== 16'd2) $display("FAIL seq_cnt: got %0d want 2", FetchCnt); else n_pass++;
        IRReady = 1'b0;
    endtask

    task automatic test_wait_hold();
        start_to_first_wait();
        IRReady = 1'b0; PCRedirect = 1'b1; RedirectAddr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_total++;
            if (IR !== 32'h0022_1800 || IRValid !== 1'b1 || PC !== 32'h4 || FetchCnt !== 16'd0)
                $display("FAIL hold_cycle%0d: ir %h valid %b pc %h cnt %0d want 00221800 1 00000004 0", i, IR, IRValid, PC, FetchCnt);
            else n_pass++;
        end
        PCRedirect = 1'b0;
    endtask

    task automatic test_redirect();
        start_to_first_wait();
        IRReady = 1'b1; PCRedirect = 1'b1; RedirectAddr = 32'h40;
        tick(1);
        n_total++; if (IAddr !== 32'h40) $display("FAIL redir_iaddr: got %h want %h", IAddr, 32'h40); else n_pass++;
        IRReady = 1'b0; PCRedirect = 1'b0;
        tick(1);
        n_total++; if (IR !== 32'h2000_0040) $display("FAIL redir_ir: got %h want %h", IR, 32'h2000_0040); else n_pass++;
        n_total++; if (PC !== 32'h44) $display("FAIL redir_pc: got %h want %h", PC, 32'h44); else n_pass++;
        IRReady = 1'b1; PCRedirect = 1'b1; RedirectAddr = 32'h42;
        tick(1);
        n_total++; if (FaultCause !== 2'b01) $display("FAIL misalign_fault: got %b want 01", FaultCause); else n_pass++;
        n_total++; if (Halt !== 1'b1) $display("FAIL misalign_halt: got %b want 1", Halt); else n_pass++;
        n_total++; if (PC !== 32'h44) $display("FAIL misalign_pc: got %h want %h", PC, 32'h44); else n_pass++;
        Start = 1'b1; RedirectAddr = 32'h40;
        tick(4);
        n_total++; if (IRValid !== 1'b0 || PC !== 32'h44 || FetchCnt !== 16'd2 || FaultCause !== 2'b01)
            $display("FAIL halt_sticky: valid %b pc %h cnt %0d fault %b want 0 00000044 2 01", IRValid, PC, FetchCnt, FaultCause); else n_pass++;
        Start = 1'b0; IRReady = 1'b0; PCRedirect = 1'b0;
    endtask

    task automatic test_halt_opcode();
        start_to_first_wait();
        IRReady = 1'b1;
        tick(4);
        n_total++; if (IR !== 32'hFC00_0000 || IRValid !== 1'b1) $display("FAIL haltop_ir: ir %h valid %b want fc000000 1", IR, IRValid); else n_pass++;
        PCRedirect = 1'b1; RedirectAddr = 32'h42;
        tick(1);
        n_total++; if (Halt !== 1'b1) $display("FAIL haltop_halt: got %b want 1", Halt); else n_pass++;
        n_total++; if (FaultCause !== 2'b00) $display("FAIL haltop_fault: got %b want 00", FaultCause); else n_pass++;
        n_total++; if (IAddr !== 32'hC) $display("FAIL haltop_iaddr: got %h want %h", IAddr, 32'hC); else n_pass++;
        n_total++; if (FetchCnt !== 16'd3) $display("FAIL haltop_cnt: got %0d want 3", FetchCnt); else n_pass++;
        PCRedirect = 1'b0;
        tick(3);
        n_total++; if (IRValid !== 1'b0) $display("FAIL haltop_novalid: got %b want 0", IRValid); else n_pass++;
        IRReady = 1'b0;
    endtask

    task automatic test_range_fault();
        start_to_first_wait();
        IRReady = 1'b1; PCRedirect = 1'b1; RedirectAddr = 32'h7C;
        tick(1);
        PCRedirect = 1'b0; IRReady = 1'b0;
        tick(1);
        n_total++; if (IR !== 32'h1111_2222 || FaultCause !== 2'b00 || Halt !== 1'b0)
            $display("FAIL range_last_ok: ir %h fault %b halt %b want 11112222 00 0", IR, FaultCause, Halt); else n_pass++;
        n_total++; if (PC !== 32'h80) $display("FAIL range_pc: got %h want %h", PC, 32'h80); else n_pass++;
        IRReady = 1'b1;
        tick(2);
        n_total++; if (FaultCause !== 2'b10 || Halt !== 1'b1) $display("FAIL range_fault: fault %b halt %b want 10 1", FaultCause, Halt); else n_pass++;
        n_total++; if (IRValid !== 1'b0 || IR !== 32'h1111_2222) $display("FAIL range_ir: valid %b ir %h want 0 11112222", IRValid, IR); else n_pass++;
        IRReady = 1'b0;
    endtask

    task automatic test_reset_mid_handshake();
        start_to_first_wait();
        IRReady = 1'b1; Reset = 1'b1;
        tick(1);
        Reset = 1'b0; IRReady = 1'b0;
        n_total++; if (IRValid !== 1'b0 || PC !== 32'h0 || FetchCnt !== 16'd0)
            $display("FAIL rst_wait: valid %b pc %h cnt %0d want 0 00000000 0", IRValid, PC, FetchCnt); else n_pass++;
        tick(3);
        n_total++; if (IRValid !== 1'b0 || PC !== 32'h0) $display("FAIL rst_idle: valid %b pc %h want 0 00000000", IRValid, PC); else n_pass++;
        Start = 1'b1;
        tick(2);
        Start = 1'b0;
        n_total++; if (IRValid !== 1'b1 || IR !== 32'h0022_1800) $display("FAIL rst_restart: valid %b ir %h want 1 00221800", IRValid, IR); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[0] = 8'h00; mem[1] = 8'h22; mem[2] = 8'h18; mem[3] = 8'h00;
        mem[4] = 8'h08; mem[5] = 8'h22; mem[6] = 8'h02; mem[7] = 8'h24;
        mem[8] = 8'hFC; mem[9] = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
        mem[64] = 8'h20; mem[65] = 8'h00; mem[66] = 8'h00; mem[67] = 8'h40;
        mem[124] = 8'h11; mem[125] = 8'h11; mem[126] = 8'h22; mem[127] = 8'h22;

        test_reset();
        test_sequential_fetch();
        test_wait_hold();
        test_redirect();
        test_halt_opcode();
        test_range_fault();
        test_reset_mid_handshake();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
